frame_update_ctrl: RTL

FRAME_UPDATE_CTRL -- requirements
Module: frame_update_ctrl

---
 rtl/frame_update_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/frame_update_ctrl.sv
// Frame-synchronous update controller: double-buffers sprite positions from the bus,
// commits them at the start of vertical blank, and runs a BCD score and run-cycle animation.
module frame_update_ctrl #(
    parameter int unsigned VACTIVE   = 480,
    parameter int unsigned SCORE_DIV = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write,
    input  logic [8:0]  address,
    input  logic [31:0] writedata,
    input  logic [9:0]  vcount,
    output logic [39:0] pos_x,
    output logic [39:0] pos_y,
    output logic [11:0] score_bcd,
    output logic [1:0]  anim_state,
    output logic        frame_tick
);

    localparam logic [9:0] VACT_LINE  = 10'(VACTIVE);
    localparam logic [3:0] SCORE_LAST = 4'(SCORE_DIV - 1);

    typedef enum logic [1:0] {
        ANIM_RUN0 = 2'd0,
        ANIM_RUN1 = 2'd1,
        ANIM_RUN2 = 2'd2
    } anim_e;

    logic [9:0]      vcount_prev_q;
    logic [4:0][7:0] shadow_x_q, shadow_x_d;
    logic [4:0][7:0] shadow_y_q, shadow_y_d;
    logic [4:0][7:0] pos_x_q, pos_x_d;
    logic [4:0][7:0] pos_y_q, pos_y_d;
    logic            frame_tick_q;
    logic            score_run_q, score_run_d;
    logic [3:0]      anim_div_q, anim_div_d;
    logic [11:0]     score_q, score_d;
    logic [3:0]      score_cnt_q, score_cnt_d;
    logic [3:0]      anim_cnt_q, anim_cnt_d;
    anim_e           anim_q, anim_d;

    logic frame_evt;
    logic wr_en, wr_shadow, wr_ctrl, wr_score;

    // Nibbles above 9 are not valid BCD; clamp each to 9.
    function automatic logic [11:0] bcd_sat(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        for (int d = 0; d < 3; d++) begin
            if (v[4*d +: 4] > 4'd9) r[4*d +: 4] = 4'd9;
        end
        return r;
    endfunction

    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int d = 0; d < 3; d++) begin
            if (carry) begin
                if (r[4*d +: 4] == 4'd9) begin
                    r[4*d +: 4] = 4'd0;
                end else begin
                    r[4*d +: 4] = r[4*d +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Rising into the first blanking line marks the frame; holding there fires only once.
    assign frame_evt = (vcount == VACT_LINE) && (vcount_prev_q != VACT_LINE);

    assign wr_en     = chipselect & write;
    assign wr_shadow = wr_en && (address < 9'd10);
    assign wr_ctrl   = wr_en && (address == 9'd10);
    assign wr_score  = wr_en && (address == 9'd11);

    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
        shadow_x_d = shadow_x_q;
        shadow_y_d = shadow_y_q;
        if (wr_shadow) begin
            if (address[0]) shadow_y_d[address[3:1]] = writedata[7:0];
            else            shadow_x_d[address[3:1]] = writedata[7:0];
        end

        // Commit takes the pre-edge shadow, so a write on the same edge waits a frame.
        pos_x_d = frame_evt ? shadow_x_q : pos_x_q;
        pos_y_d = frame_evt ? shadow_y_q : pos_y_q;

        score_run_d = wr_ctrl ? writedata[0]   : score_run_q;
        anim_div_d  = wr_ctrl ? writedata[7:4] : anim_div_q;

        score_d     = score_q;
        score_cnt_d = score_cnt_q;
        if (wr_ctrl && writedata[1]) begin
            score_d     = 12'h000;
            score_cnt_d = 4'd0;
        end else if (wr_score) begin
            score_d     = bcd_sat(writedata[11:0]);
            score_cnt_d = 4'd0;
        end else if (frame_evt && score_run_q) begin
            if (score_cnt_q >= SCORE_LAST) begin
                score_cnt_d = 4'd0;
                score_d     = bcd_inc(score_q);
            end else begin
                score_cnt_d = score_cnt_q + 4'd1;
            end
        end

        anim_cnt_d = anim_cnt_q;
        anim_d     = anim_q;
        if (wr_ctrl) begin
            anim_cnt_d = 4'd0;
        end else if (frame_evt && (anim_div_q != 4'd0)) begin
            if (anim_cnt_q == anim_div_q - 4'd1) begin
                anim_cnt_d = 4'd0;
                case (anim_q)
                    ANIM_RUN0: anim_d = ANIM_RUN1;
                    ANIM_RUN1: anim_d = ANIM_RUN2;
                    default:   anim_d = ANIM_RUN0;
                endcase
            end else begin
                anim_cnt_d = anim_cnt_q + 4'd1;
            end
        end
    end

    // NOTE: the shadow bank is plain flops, not RAM, so it can and does take the async reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vcount_prev_q <= '0;
            shadow_x_q    <= '0;
            shadow_y_q    <= '0;
            pos_x_q       <= '0;
            pos_y_q       <= '0;
            frame_tick_q  <= 1'b0;
            score_run_q   <= 1'b0;
            anim_div_q    <= 4'd0;
            score_q       <= 12'h000;
            score_cnt_q   <= 4'd0;
            anim_cnt_q    <= 4'd0;
            anim_q        <= ANIM_RUN0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            vcount_prev_q <= vcount;
            shadow_x_q    <= shadow_x_d;
            shadow_y_q    <= shadow_y_d;
            pos_x_q       <= pos_x_d;
            pos_y_q       <= pos_y_d;
            frame_tick_q  <= frame_evt;
            score_run_q   <= score_run_d;
            anim_div_q    <= anim_div_d;
            score_q       <= score_d;
            score_cnt_q   <= score_cnt_d;
            anim_cnt_q    <= anim_cnt_d;
            anim_q        <= anim_d;
        end
    end

    assign pos_x      = pos_x_q;
    assign pos_y      = pos_y_q;
    assign score_bcd  = score_q;
    assign anim_state = anim_q;
    assign frame_tick = frame_tick_q;

endmodule
